// File: rtl/data_path_if.sv
// Controller-side bundle for the datapath: register/bus control strobes plus the
// address and opcode returned to the controller and memory.
interface data_path_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned OP_W   = 2;

  logic              ir_on_adr;
  logic              pc_on_adr;
  logic              dbus_on_data;
  logic              data_on_dbus;
  logic              ld_ir;
  logic              ld_ac;
  logic              ld_pc;
  logic              inc_pc;
  logic              pass;
  logic              add;
  logic              alu_on_dbus;
  logic [ADDR_W-1:0] adr_bus;
  logic [OP_W-1:0]   op_code;

  modport master (
    output ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus,
    output ld_ir, ld_ac, ld_pc, inc_pc, pass, add, alu_on_dbus,
    input  adr_bus, op_code
  );

  modport slave (
    input  ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus,
    input  ld_ir, ld_ac, ld_pc, inc_pc, pass, add, alu_on_dbus,
    output adr_bus, op_code
  );
endinterface

// File: rtl/data_path.sv
// Tiny RISC CPU datapath: PC, IR, AC, 8-bit ALU and the steering between them,
// the external memory address bus and the bidirectional memory data bus.
module data_path (
  input  logic           clk,
  input  logic           clr_pc,
  data_path_if.slave     ctl,
  inout  wire  [7:0]     data_bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned OP_W   = 2;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;

  logic [DATA_W-1:0] alu_opnd;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] dbus;
  logic              drive_data;

  // The ALU operand never comes from its own result, so dbus has no loop.
  always_comb begin
    alu_opnd = '0;
    if (ctl.data_on_dbus) alu_opnd = data_bus;
  end

  always_comb begin
    alu_res = ac;
    if (ctl.add)       alu_res = DATA_W'(ac + alu_opnd);
    else if (ctl.pass) alu_res = alu_opnd;
  end

  always_comb begin
    dbus = alu_opnd;
    if (ctl.alu_on_dbus) dbus = alu_res;
  end

  // Never drive the memory bus while memory is driving it.
  assign drive_data = ctl.dbus_on_data & ~ctl.data_on_dbus;
  assign data_bus   = drive_data ? dbus : {DATA_W{1'bz}};

  always_comb begin
    ctl.adr_bus = '0;
    if (ctl.ir_on_adr)      ctl.adr_bus = ir[ADDR_W-1:0];
    else if (ctl.pc_on_adr) ctl.adr_bus = pc;
  end

  assign ctl.op_code = ir[DATA_W-1 -: OP_W];

  always_ff @(posedge clk) begin
    if (clr_pc) begin
      pc <= '0;
      ir <= '0;
      ac <= '0;
    end else begin
      if (ctl.ld_ir) ir <= dbus;
      if (ctl.ld_ac) ac <= alu_res;
      if (ctl.ld_pc)       pc <= ir[ADDR_W-1:0];
      else if (ctl.inc_pc) pc <= ADDR_W'(pc + ADDR_W'(1));
    end
  end
endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed sequences, a combinational vector
// table and randomized cycles checked against an arithmetic reference model.
module tb_data_path;
  logic       clk;
  logic       clr_pc;
  logic       tb_en;
  logic [7:0] tb_drv;
  wire  [7:0] data_bus;

  int total = 0;
  int bad   = 0;

  data_path_if bus ();

  assign data_bus = tb_en ? tb_drv : 8'hzz;

  data_path dut (
    .clk      (clk),
    .clr_pc   (clr_pc),
    .ctl      (bus),
    .data_bus (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ir_on, pc_on, alu_on, data_on, dbus_on, add, pass, en;
    logic [7:0] val;
    logic [5:0] exp_adr;
    logic [1:0] exp_op;
    logic       chk_db;
    logic [7:0] exp_db;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clr_pc = 0; tb_en = 0; tb_drv = 8'h00;
    bus.ir_on_adr = 0; bus.pc_on_adr = 0; bus.dbus_on_data = 0; bus.data_on_dbus = 0;
    bus.ld_ir = 0; bus.ld_ac = 0; bus.ld_pc = 0; bus.inc_pc = 0;
    bus.pass = 0; bus.add = 0; bus.alu_on_dbus = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Reads PC, IR and AC through the external buses; call just after step().
  task automatic obs(input string tag, input int pc, input int ir, input int ac);
    logic [7:0] irv;
    irv = 8'(ir);
    idle();
    bus.pc_on_adr = 1;
    #1 chk({tag, ".pc"}, 8'(bus.adr_bus), 8'(pc % 64));
    bus.pc_on_adr = 0; bus.ir_on_adr = 1;
    #1 chk({tag, ".ir_adr"}, 8'(bus.adr_bus), 8'(irv[5:0]));
    chk({tag, ".op"}, 8'(bus.op_code), 8'(irv[7:6]));
    bus.ir_on_adr = 0; bus.alu_on_dbus = 1; bus.dbus_on_data = 1;
    #1 chk({tag, ".ac"}, data_bus, 8'(ac));
    idle();
  endtask

  task automatic mem_read(input logic [7:0] v);
    tb_en = 1; tb_drv = v; bus.data_on_dbus = 1;
  endtask

  // Reference model state
  int m_pc, m_ir, m_ac;

  initial begin
    int opnd, alu, dbv, n_pc;
    logic [7:0] tmp;
    logic       clr, li, la, lp, ip, ion, pon, aon, don, bon, ad, ps;

    vecs[0] = '{1,1,0,0,0,0,0,0, 8'h00, 6'h25, 2'b10, 0, 8'h00};
    vecs[1] = '{0,1,0,0,0,0,0,0, 8'h00, 6'h01, 2'b10, 0, 8'h00};
    vecs[2] = '{0,0,0,0,0,0,0,0, 8'h00, 6'h00, 2'b10, 0, 8'h00};
    vecs[3] = '{0,0,1,0,1,0,0,0, 8'h00, 6'h00, 2'b10, 1, 8'h0C};
    vecs[4] = '{0,0,1,0,1,1,0,0, 8'h00, 6'h00, 2'b10, 1, 8'h0C};
    vecs[5] = '{0,0,1,0,1,0,1,0, 8'h00, 6'h00, 2'b10, 1, 8'h00};
    vecs[6] = '{0,0,0,0,1,0,0,0, 8'h00, 6'h00, 2'b10, 1, 8'h00};
    vecs[7] = '{0,1,1,1,1,1,0,1, 8'h33, 6'h01, 2'b10, 1, 8'h33};
    vecs[8] = '{1,0,1,0,0,0,0,1, 8'hF3, 6'h25, 2'b10, 1, 8'hF3};

    idle();
    // Reset overrides loads asserted in the same cycle
    clr_pc = 1; bus.ld_ir = 1; bus.ld_ac = 1; bus.inc_pc = 1; bus.pass = 1;
    mem_read(8'hA5);
    step();
    chk("rst.op", 8'(bus.op_code), 8'h00);
    bus.pc_on_adr = 1;
    #1 chk("rst.adr_pc", 8'(bus.adr_bus), 8'h00);
    bus.pc_on_adr = 0; bus.ir_on_adr = 1;
    #1 chk("rst.adr_ir", 8'(bus.adr_bus), 8'h00);
    bus.ir_on_adr = 0;
    #1 chk("rst.adr_none", 8'(bus.adr_bus), 8'h00);
    tb_en = 1; tb_drv = 8'hA5;
    #1 chk("rst.db_z", data_bus, 8'hA5);
    obs("rst", 0, 0, 0);

    // Fetch
    bus.pc_on_adr = 1;
    #1 chk("fetch.adr", 8'(bus.adr_bus), 8'h00);
    mem_read(8'hA5); bus.ld_ir = 1; bus.inc_pc = 1;
    step();
    chk("fetch.op", 8'(bus.op_code), 8'h02);
    obs("fetch", 1, 8'hA5, 0);

    // Load then add with wrap
    mem_read(8'h3C); bus.pass = 1; bus.ld_ac = 1;
    step();
    obs("load", 1, 8'hA5, 8'h3C);
    mem_read(8'hD0); bus.add = 1; bus.ld_ac = 1;
    step();
    obs("add", 1, 8'hA5, 8'h0C);

    // Combinational steering vectors at PC=1, IR=A5, AC=0C
    foreach (vecs[i]) begin
      idle();
      bus.ir_on_adr = vecs[i].ir_on; bus.pc_on_adr = vecs[i].pc_on;
      bus.alu_on_dbus = vecs[i].alu_on; bus.data_on_dbus = vecs[i].data_on;
      bus.dbus_on_data = vecs[i].dbus_on; bus.add = vecs[i].add; bus.pass = vecs[i].pass;
      tb_en = vecs[i].en; tb_drv = vecs[i].val;
      #1;
      chk($sformatf("vec%0d.adr", i), 8'(bus.adr_bus), 8'(vecs[i].exp_adr));
      chk($sformatf("vec%0d.op", i), 8'(bus.op_code), 8'(vecs[i].exp_op));
      if (vecs[i].chk_db) chk($sformatf("vec%0d.db", i), data_bus, vecs[i].exp_db);
      step();
    end

    // Store and release
    mem_read(8'h5A); bus.pass = 1; bus.ld_ac = 1;
    step();
    bus.alu_on_dbus = 1; bus.dbus_on_data = 1;
    #1 chk("store.db", data_bus, 8'h5A);
    bus.dbus_on_data = 0; tb_en = 1; tb_drv = 8'hA5;
    #1 chk("store.release", data_bus, 8'hA5);
    idle();

    // Jump beats increment, then PC wraps
    mem_read(8'hFF); bus.ld_ir = 1;
    step();
    bus.ld_pc = 1; bus.inc_pc = 1;
    step();
    obs("jump", 63, 8'hFF, 8'h5A);
    bus.inc_pc = 1;
    step();
    obs("wrap", 0, 8'hFF, 8'h5A);

    // Randomized cycles against the model
    m_pc = 0; m_ir = 8'hFF; m_ac = 8'h5A;
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 19) == 0);
      li = 1'($urandom); la = 1'($urandom); lp = 1'($urandom); ip = 1'($urandom);
      ion = 1'($urandom); pon = 1'($urandom); aon = 1'($urandom);
      don = 1'($urandom); bon = 1'($urandom); ad = 1'($urandom); ps = 1'($urandom);
      tmp = 8'($urandom);
      clr_pc = clr; bus.ld_ir = li; bus.ld_ac = la; bus.ld_pc = lp; bus.inc_pc = ip;
      bus.ir_on_adr = ion; bus.pc_on_adr = pon; bus.alu_on_dbus = aon;
      bus.data_on_dbus = don; bus.dbus_on_data = bon; bus.add = ad; bus.pass = ps;
      tb_drv = tmp;
      tb_en = don | (!bon & 1'($urandom));

      opnd = don ? int'(tmp) : 0;
      if (ad)      alu = (m_ac + opnd) % 256;
      else if (ps) alu = opnd;
      else         alu = m_ac;
      dbv = aon ? alu : opnd;
      #1;
      chk($sformatf("rnd%0d.adr", c), 8'(bus.adr_bus),
          8'(ion ? m_ir % 64 : (pon ? m_pc : 0)));
      chk($sformatf("rnd%0d.op", c), 8'(bus.op_code), 8'(m_ir / 64));
      if (bon && !don) chk($sformatf("rnd%0d.db", c), data_bus, 8'(dbv));
      else if (tb_en)  chk($sformatf("rnd%0d.dbz", c), data_bus, tmp);

      if (clr) begin
        m_pc = 0; m_ir = 0; m_ac = 0;
      end else begin
        n_pc = lp ? m_ir % 64 : (ip ? (m_pc + 1) % 64 : m_pc);
        if (li) m_ir = dbv;
        if (la) m_ac = alu;
        m_pc = n_pc;
      end
      step();
    end
    obs("rnd.final", m_pc, m_ir, m_ac);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
